// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and size helpers for the byte-serial memory access controller.
package mem_access_pkg;

  localparam logic [2:0] MS_BYTE  = 3'b000;
  localparam logic [2:0] MS_HALF  = 3'b001;
  localparam logic [2:0] MS_WORD  = 3'b010;
  localparam logic [2:0] MS_SBYTE = 3'b100;
  localparam logic [2:0] MS_SHALF = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } mac_state_e;

  // Reserved size codes fall through to a full word.
  function automatic logic [2:0] byte_count(input logic [2:0] ms);
    case (ms)
      MS_BYTE, MS_SBYTE: byte_count = 3'd1;
      MS_HALF, MS_SHALF: byte_count = 3'd2;
      default:           byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] ms, input logic [1:0] addr_lo);
    case (byte_count(ms))
      3'd2:    is_misaligned = addr_lo[0];
      3'd4:    is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mac_load_extend.sv
// Combinational load formatter: right-justified assembled bytes are zero- or
// sign-extended according to the access size.
module mac_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [2:0]  ms_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (ms_i)
      MS_BYTE:  data_o = {24'h000000, raw_i[7:0]};
      MS_SBYTE: data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      MS_HALF:  data_o = {16'h0000, raw_i[15:0]};
      MS_SHALF: data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      default:  data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-serial big-endian load/store controller between a CPU MAR/MDR and a byte RAM.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with ALIGN_ERR.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
)
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MOV,
  input  logic              RW,
  input  logic [2:0]        MS,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       DATA_IN,
  output logic              MOC,
  output logic [31:0]       DATA_OUT,
  output logic              ALIGN_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  output logic              MEM_WE,
  input  logic [7:0]        MEM_RDATA
);

  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam int WCNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(HAS_WAIT ? WAIT_CYCLES - 1 : 0);
  localparam mac_state_e BYTE_START = HAS_WAIT ? ST_WAIT : ST_XFER;

  mac_state_e        state_q, state_d;
  logic              rw_q, rw_d;
  logic [2:0]        ms_q, ms_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]       dout_q, dout_d;

  logic [2:0]        nbytes;
  logic [1:0]        last_idx;
  logic [31:0]       assembled;
  logic [31:0]       load_ext;

  assign nbytes    = byte_count(ms_q);
  assign last_idx  = 2'(nbytes - 3'd1);
  assign assembled = {shift_q[23:0], MEM_RDATA};

  mac_load_extend u_load_extend (
    .raw_i  (assembled),
    .ms_i   (ms_q),
    .data_o (load_ext)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic aerr_q, aerr_d;
`endif

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    ms_d    = ms_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    dout_d  = dout_q;
`ifdef MEM_ALIGN_CHECK_EN
    aerr_d  = aerr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (MOV) begin
          rw_d    = RW;
          ms_d    = MS;
          addr_d  = ADDR[ADDR_W-1:0];
          idx_d   = 2'd0;
          wcnt_d  = '0;
          state_d = BYTE_START;
          // Store data is pre-shifted so the most significant byte to send sits in [31:24].
          if (RW) begin
            shift_d = 32'h0;
          end else begin
            case (byte_count(MS))
              3'd1:    shift_d = {DATA_IN[7:0], 24'h000000};
              3'd2:    shift_d = {DATA_IN[15:0], 16'h0000};
              default: shift_d = DATA_IN;
            endcase
          end
`ifdef MEM_ALIGN_CHECK_EN
          aerr_d = 1'b0;
          if (is_misaligned(MS, ADDR[1:0])) begin
            aerr_d  = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d  = '0;
          state_d = ST_XFER;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        shift_d = assembled;
        if (idx_q == last_idx) begin
          state_d = ST_DONE;
          if (rw_q) begin
            dout_d = load_ext;
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = BYTE_START;
        end
      end
      ST_DONE: begin
        if (!MOV) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      ms_q    <= 3'b000;
      addr_q  <= '0;
      shift_q <= 32'h0;
      idx_q   <= 2'd0;
      wcnt_q  <= '0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      ms_q    <= ms_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      dout_q  <= dout_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      aerr_q <= 1'b0;
    end else begin
      aerr_q <= aerr_d;
    end
  end
  assign ALIGN_ERR = aerr_q;
`else
  assign ALIGN_ERR = 1'b0;
`endif

  // Byte k of the access lands at ADDR+k, wrapping naturally at the top of the array.
  assign MEM_ADDR  = addr_q + ADDR_W'(idx_q);
  assign MEM_WDATA = shift_q[31:24];
  assign MEM_WE    = (state_q == ST_XFER) && !rw_q;
  assign MOC       = (state_q == ST_DONE);
  assign DATA_OUT  = dout_q;

  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDR[31:ADDR_W];
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl: one zero-wait and one two-wait instance,
// each backed by its own 256-byte RAM model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        mov0 = 1'b0;
  logic        mov2 = 1'b0;
  logic        rw = 1'b0;
  logic [2:0]  ms = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;

  logic        moc0, moc2, aerr0, aerr2, we0, we2;
  logic [31:0] dout0, dout2;
  logic [7:0]  maddr0, maddr2, wdata0, wdata2, rdata0, rdata2;

  logic [7:0]  mem0 [256] = '{default: 8'h00};
  logic [7:0]  mem2 [256] = '{default: 8'h00};
  int          we_cnt0 = 0;
  int          we_cnt2 = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] dout;
    logic        aerr;
    int          lat;
    int          we;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .MOV(mov0), .RW(rw), .MS(ms), .ADDR(addr), .DATA_IN(din),
    .MOC(moc0), .DATA_OUT(dout0), .ALIGN_ERR(aerr0), .MEM_ADDR(maddr0),
    .MEM_WDATA(wdata0), .MEM_WE(we0), .MEM_RDATA(rdata0)
  );

  mem_access_ctrl #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .MOV(mov2), .RW(rw), .MS(ms), .ADDR(addr), .DATA_IN(din),
    .MOC(moc2), .DATA_OUT(dout2), .ALIGN_ERR(aerr2), .MEM_ADDR(maddr2),
    .MEM_WDATA(wdata2), .MEM_WE(we2), .MEM_RDATA(rdata2)
  );

  assign rdata0 = mem0[maddr0];
  assign rdata2 = mem2[maddr2];

  always @(posedge CLK) begin
    if (we0) begin
      mem0[maddr0] <= wdata0;
      we_cnt0      <= we_cnt0 + 1;
    end
    if (we2) begin
      mem2[maddr2] <= wdata2;
      we_cnt2      <= we_cnt2 + 1;
    end
  end

  function automatic logic moc_of(input int sel);
    return (sel == 0) ? moc0 : moc2;
  endfunction

  function automatic logic aerr_of(input int sel);
    return (sel == 0) ? aerr0 : aerr2;
  endfunction

  function automatic logic [31:0] dout_of(input int sel);
    return (sel == 0) ? dout0 : dout2;
  endfunction

  function automatic int wecnt_of(input int sel);
    return (sel == 0) ? we_cnt0 : we_cnt2;
  endfunction

  task automatic set_mov(input int sel, input logic v);
    if (sel == 0) mov0 = v;
    else          mov2 = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request, queues its expectation, then waits (bounded) for MOC and scores it.
  task automatic do_access(input int sel, input logic rw_v, input logic [2:0] ms_v,
                           input logic [31:0] addr_v, input logic [31:0] din_v,
                           input logic [31:0] exp_dout, input logic exp_aerr,
                           input int exp_lat, input int exp_we,
                           input int drop_at, input int hold, input bit scramble,
                           input string tag);
    exp_t e;
    int   edges;
    int   we_start;
    bit   seen;
    @(negedge CLK);
    rw = rw_v; ms = ms_v; addr = addr_v; din = din_v;
    set_mov(sel, 1'b1);
    e.tag = tag; e.dout = exp_dout; e.aerr = exp_aerr; e.lat = exp_lat; e.we = exp_we;
    sb.push_back(e);
    we_start = wecnt_of(sel);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (moc_of(sel)) seen = 1'b1;
      if (scramble && edges == 1) begin
        addr = 32'hFFFF_FFFF; din = 32'hFFFF_FFFF; ms = 3'b000; rw = ~rw_v;
      end
      if (drop_at != 0 && edges == drop_at) set_mov(sel, 1'b0);
    end
    e = sb.pop_front();
    check({e.tag, "_moc_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({e.tag, "_latency"}, edges, e.lat);
      check({e.tag, "_dout"}, dout_of(sel), e.dout);
      check({e.tag, "_align_err"}, 32'(aerr_of(sel)), 32'(e.aerr));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check({e.tag, "_moc_held"}, 32'(moc_of(sel)), 32'd1);
    end
    set_mov(sel, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    check({e.tag, "_moc_drop"}, 32'(moc_of(sel)), 32'd0);
    check({e.tag, "_we_pulses"}, wecnt_of(sel) - we_start, e.we);
  endtask

  initial begin
    int ws;
    #2 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_moc", 32'(moc0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_align", 32'(aerr0), 32'd0);
    check("rst_dout", dout0, 32'h0);
    check("rst_maddr", 32'(maddr0), 32'h0);
    check("rst_wdata", 32'(wdata0), 32'h0);
    check("rst_moc2", 32'(moc2), 32'd0);
    RESET = 1'b1;

    // Zero-wait instance.
    do_access(0, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4, 0, 0, 0, "wr_word");
    check("mem_word_10", {mem0[8'h10], mem0[8'h11], mem0[8'h12], mem0[8'h13]}, 32'hDEADBEEF);
    do_access(0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 0, 0, 0, 0, "rd_word");
    do_access(0, 1'b0, 3'b000, 32'h20, 32'h12345680, 32'hDEADBEEF, 1'b0, 2, 1, 0, 0, 0, "wr_byte");
    check("mem_byte_20", 32'(mem0[8'h20]), 32'h80);
    check("mem_byte_21", 32'(mem0[8'h21]), 32'h00);
    do_access(0, 1'b1, 3'b100, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 0, 0, 0, "rd_sbyte");
    do_access(0, 1'b1, 3'b000, 32'h20, 32'h0, 32'h00000080, 1'b0, 2, 0, 0, 0, 0, "rd_ubyte");
`ifdef MEM_ALIGN_CHECK_EN
    do_access(0, 1'b0, 3'b001, 32'hFF, 32'hAAAA1234, 32'h00000080, 1'b1, 1, 0, 0, 0, 0, "wr_half_ff");
    check("mem_ff", 32'(mem0[8'hFF]), 32'h00);
    check("mem_00", 32'(mem0[8'h00]), 32'h00);
`else
    do_access(0, 1'b0, 3'b001, 32'hFF, 32'hAAAA1234, 32'h00000080, 1'b0, 3, 2, 0, 0, 0, "wr_half_ff");
    check("mem_ff", 32'(mem0[8'hFF]), 32'h12);
    check("mem_00", 32'(mem0[8'h00]), 32'h34);
`endif
    do_access(0, 1'b0, 3'b001, 32'h40, 32'h00008001, 32'h00000080, 1'b0, 3, 2, 0, 0, 0, "wr_half_40");
    do_access(0, 1'b1, 3'b101, 32'h40, 32'h0, 32'hFFFF8001, 1'b0, 3, 0, 0, 0, 0, "rd_shalf");
    do_access(0, 1'b1, 3'b001, 32'h40, 32'h0, 32'h00008001, 1'b0, 3, 0, 0, 3, 0, "rd_uhalf_hold");
`ifdef MEM_ALIGN_CHECK_EN
    do_access(0, 1'b1, 3'b010, 32'h02, 32'h0, 32'h00008001, 1'b1, 1, 0, 0, 0, 0, "rd_word_02");
`else
    do_access(0, 1'b1, 3'b010, 32'h02, 32'h0, 32'h00000000, 1'b0, 5, 0, 0, 0, 0, "rd_word_02");
`endif
    do_access(0, 1'b1, 3'b011, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 0, 0, 0, 0, "rd_reserved");
    do_access(0, 1'b0, 3'b010, 32'h50, 32'h01020304, 32'hDEADBEEF, 1'b0, 5, 4, 0, 0, 1, "wr_scramble");
    check("mem_word_50", {mem0[8'h50], mem0[8'h51], mem0[8'h52], mem0[8'h53]}, 32'h01020304);

    // Two-wait instance; MOV released mid-transfer on the first access.
    do_access(2, 1'b0, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 13, 4, 3, 0, 0, "w2_wr_drop");
    check("mem2_word_30", {mem2[8'h30], mem2[8'h31], mem2[8'h32], mem2[8'h33]}, 32'hCAFEF00D);
    do_access(2, 1'b1, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 13, 0, 0, 0, 0, "w2_rd_word");
    do_access(2, 1'b1, 3'b100, 32'h33, 32'h0, 32'h0000000D, 1'b0, 4, 0, 0, 0, 0, "w2_rd_byte");

    // Reset after the second byte of a word store.
    @(negedge CLK);
    rw = 1'b0; ms = 3'b010; addr = 32'h60; din = 32'h11223344; mov0 = 1'b1;
    ws = we_cnt0;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    RESET = 1'b0;
    mov0  = 1'b0;
    #1;
    check("midrst_moc", 32'(moc0), 32'd0);
    check("midrst_we", 32'(we0), 32'd0);
    check("midrst_dout", dout0, 32'h0);
    check("midrst_maddr", 32'(maddr0), 32'h0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("midrst_we_pulses", we_cnt0 - ws, 32'd2);
    check("midrst_mem_60", {mem0[8'h60], mem0[8'h61], mem0[8'h62], mem0[8'h63]}, 32'h11220000);
    check("midrst_moc_after", 32'(moc0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
